// File: rtl/wb_csr_pkg.sv
// Shared definitions for the Wishbone-to-CSR bridge: cycle-type codes,
// the bridge state encoding and a byte-select helper.
package wb_csr_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    ACK
  } state_t;

  // Only full-word writes reach the CSR bus; partial writes are acked and dropped.
  function automatic logic full_word(input logic [3:0] sel);
    return sel == 4'hF;
  endfunction

endpackage

// File: rtl/wb_csr_bridge.sv
// Wishbone slave to CSR bus bridge with fixed-latency read return.
// Define WB_CSR_BRIDGE_BURST_EN to support incrementing bursts (cti=010).
module wb_csr_bridge
  import wb_csr_pkg::*;
#(
  parameter int CSR_AW = 14,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [2:0]        wb_cti_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_do,
  input  logic [31:0]       csr_di
);

  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT - 1);

  state_t        r_state;
  logic [LW-1:0] r_lat_cnt;
  logic          w_req;
  logic          w_unused_bits;

  assign w_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

`ifdef WB_CSR_BRIDGE_BURST_EN
  // Set while the beat currently being served promised a following beat.
  logic r_incr;
  logic w_next_beat;

  assign w_next_beat   = r_incr & wb_cyc_i & wb_stb_i;
  assign w_unused_bits = ^{wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};
`else
  assign w_unused_bits = ^{wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0], wb_cti_i};
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      csr_a     <= '0;
      csr_we    <= 1'b0;
      csr_do    <= '0;
`ifdef WB_CSR_BRIDGE_BURST_EN
      r_incr    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          csr_we   <= 1'b0;
          if (w_req) begin
            csr_a  <= wb_adr_i[CSR_AW+1:2];
            csr_do <= wb_dat_i;
`ifdef WB_CSR_BRIDGE_BURST_EN
            r_incr <= (wb_cti_i == CTI_INCR);
`endif
            if (wb_we_i) begin
              // Write strobe and ack are raised together on the sampling edge.
              csr_we   <= full_word(wb_sel_i);
              wb_ack_o <= 1'b1;
              r_state  <= WRITE;
            end else begin
              r_lat_cnt <= LAT_LOAD;
              r_state   <= READ;
            end
          end
        end

        WRITE: begin
`ifdef WB_CSR_BRIDGE_BURST_EN
          if (w_next_beat) begin
            csr_a    <= csr_a + CSR_AW'(1);
            csr_do   <= wb_dat_i;
            csr_we   <= full_word(wb_sel_i);
            wb_ack_o <= 1'b1;
            r_incr   <= (wb_cti_i == CTI_INCR);
          end else
`endif
          begin
            csr_we   <= 1'b0;
            wb_ack_o <= 1'b0;
            r_state  <= IDLE;
          end
        end

        READ: begin
          csr_we <= 1'b0;
          // The count runs to completion even if the master abandons the cycle.
          if (r_lat_cnt == '0) begin
            wb_dat_o <= csr_di;
            wb_ack_o <= 1'b1;
            r_state  <= ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end

        ACK: begin
          wb_ack_o <= 1'b0;
`ifdef WB_CSR_BRIDGE_BURST_EN
          if (w_next_beat) begin
            csr_a     <= csr_a + CSR_AW'(1);
            r_lat_cnt <= LAT_LOAD;
            r_incr    <= (wb_cti_i == CTI_INCR);
            r_state   <= READ;
          end else
`endif
          begin
            r_state <= IDLE;
          end
        end

        default: begin
          wb_ack_o <= 1'b0;
          csr_we   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Directed bench for wb_csr_bridge (RD_LAT=3); burst vectors run only when
// WB_CSR_BRIDGE_BURST_EN is defined, otherwise cti=010 is checked as classic.
module tb_wb_csr_bridge;

  localparam int CSR_AW = 14;
  localparam int RD_LAT = 3;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [31:0]       wb_adr_i = '0;
  logic [31:0]       wb_dat_i = '0;
  logic [31:0]       wb_dat_o;
  logic [2:0]        wb_cti_i = '0;
  logic [3:0]        wb_sel_i = '0;
  logic              wb_we_i = 1'b0;
  logic              wb_cyc_i = 1'b0;
  logic              wb_stb_i = 1'b0;
  logic              wb_ack_o;
  logic [CSR_AW-1:0] csr_a;
  logic              csr_we;
  logic [31:0]       csr_do;
  logic [31:0]       csr_di = '0;

  int n_checks = 0;
  int n_errors = 0;

  wb_csr_bridge #(.CSR_AW(CSR_AW), .RD_LAT(RD_LAT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_cti_i(wb_cti_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .csr_di  (csr_di)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'h0;
    wb_cti_i = 3'b000;
    wb_adr_i = '0;
    wb_dat_i = '0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cti_i = cti;
  endtask

  // Ticks until ack is visible; n is the number of ticks taken (limit on timeout).
  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (wb_ack_o !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int acks, output int wes);
    acks = 0;
    wes  = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (wb_ack_o === 1'b1) acks++;
      if (csr_we === 1'b1) wes++;
    end
  endtask

  initial begin
    int n;
    int acks;
    int wes;

    // Reset state
    repeat (3) tick();
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_we", {31'd0, csr_we}, 32'd0);
    check("rst_csr_a", 32'(csr_a), 32'd0);
    check("rst_csr_do", csr_do, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    sys_rst = 1'b0;
    tick();
    $display("txn reset released");

    // Full-word write: strobe and ack both visible right after the sampling edge
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000);
    tick();
    check("wr_csr_a", 32'(csr_a), 32'd4);
    check("wr_csr_do", csr_do, 32'hDEAD_BEEF);
    check("wr_we", {31'd0, csr_we}, 32'd1);
    check("wr_ack", {31'd0, wb_ack_o}, 32'd1);
    tick();
    bus_idle();
    check("wr_we_1cyc", {31'd0, csr_we}, 32'd0);
    check("wr_ack_1cyc", {31'd0, wb_ack_o}, 32'd0);
    count_pulses(4, acks, wes);
    check("wr_no_extra_ack", 32'(acks), 32'd0);
    check("wr_no_extra_we", 32'(wes), 32'd0);
    $display("txn write adr=0x00000010 dat=0xDEADBEEF sel=F");

    // Partial write: acked, never strobed
    drive(1'b1, 32'h0000_0014, 32'h0000_AAAA, 4'h3, 3'b000);
    tick();
    check("pw_ack", {31'd0, wb_ack_o}, 32'd1);
    check("pw_we", {31'd0, csr_we}, 32'd0);
    check("pw_csr_a", 32'(csr_a), 32'd5);
    tick();
    bus_idle();
    count_pulses(3, acks, wes);
    check("pw_no_we", 32'(wes), 32'd0);
    $display("txn write adr=0x00000014 dat=0x0000AAAA sel=3");

    // Read, RD_LAT=3: ack rises 3 edges after sampling, so the master sees it on the 4th
    csr_di = 32'h1234_5678;
    drive(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b000);
    tick();
    check("rd_csr_a", 32'(csr_a), 32'd8);
    check("rd_ack_early", {31'd0, wb_ack_o}, 32'd0);
    wait_ack(12, n);
    check("rd_latency", 32'(n), 32'(RD_LAT));
    check("rd_data", wb_dat_o, 32'h1234_5678);
    $display("txn read adr=0x00000020 data=0x%08h", wb_dat_o);

    // Classic back-to-back read: one IDLE turnaround plus RD_LAT between pulses
    csr_di = 32'hBAD0_BAD0;
    tick();
    check("b2b_ack_single", {31'd0, wb_ack_o}, 32'd0);
    check("b2b_data_hold", wb_dat_o, 32'h1234_5678);
    drive(1'b0, 32'h0000_0024, 32'h0, 4'hF, 3'b000);
    csr_di = 32'hCAFE_F00D;
    wait_ack(12, n);
    check("b2b_gap", 32'(n), 32'(RD_LAT + 1));
    check("b2b_csr_a", 32'(csr_a), 32'd9);
    check("b2b_data", wb_dat_o, 32'hCAFE_F00D);
    tick();
    bus_idle();
    check("b2b_ack_end", {31'd0, wb_ack_o}, 32'd0);
    count_pulses(6, acks, wes);
    check("b2b_no_dup", 32'(acks), 32'd0);
    $display("txn read adr=0x00000024 data=0x%08h", wb_dat_o);

    // cyc dropped mid-read: latency still completes with one ack pulse
    csr_di = 32'h0F0F_0F0F;
    drive(1'b0, 32'h0000_0040, 32'h0, 4'hF, 3'b000);
    tick();
    bus_idle();
    wait_ack(12, n);
    check("drop_latency", 32'(n), 32'(RD_LAT));
    check("drop_data", wb_dat_o, 32'h0F0F_0F0F);
    count_pulses(4, acks, wes);
    check("drop_single_ack", 32'(acks), 32'd0);
    $display("txn read adr=0x00000040 abandoned by master");

    // Reset one cycle into a read: no ack, everything back to reset values
    csr_di = 32'h5555_5555;
    drive(1'b0, 32'h0000_0030, 32'h0, 4'hF, 3'b000);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    check("mrst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("mrst_we", {31'd0, csr_we}, 32'd0);
    check("mrst_csr_a", 32'(csr_a), 32'd0);
    check("mrst_csr_do", csr_do, 32'd0);
    check("mrst_dat_o", wb_dat_o, 32'd0);
    sys_rst = 1'b0;
    bus_idle();
    count_pulses(6, acks, wes);
    check("mrst_no_ack", 32'(acks), 32'd0);
    $display("txn read adr=0x00000030 aborted by reset");

    // Back in IDLE: a write is accepted at once; upper address bits are ignored
    drive(1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 3'b000);
    tick();
    check("wrap_ack", {31'd0, wb_ack_o}, 32'd1);
    check("wrap_csr_a", 32'(csr_a), 32'h3FFF);
    tick();
    drive(1'b1, 32'hFFFF_0008, 32'h0000_0002, 4'hF, 3'b000);
    tick();
    check("hi_bits_csr_a", 32'(csr_a), 32'd2);
    check("hi_bits_csr_do", csr_do, 32'd2);
    tick();
    bus_idle();
    tick();
    $display("txn writes adr=0xFFFFFFFC and adr=0xFFFF0008");

`ifdef WB_CSR_BRIDGE_BURST_EN
    // 4-beat incrementing write burst, one beat per cycle
    drive(1'b1, 32'h0000_0040, 32'hA000_0000, 4'hF, 3'b010);
    tick();
    check("bw_csr_a_0", 32'(csr_a), 32'd16);
    check("bw_we_0", {31'd0, csr_we}, 32'd1);
    check("bw_ack_0", {31'd0, wb_ack_o}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h0000_0040 + 32'(4 * k), 32'hA000_0000 + 32'(k),
            4'hF, (k == 3) ? 3'b111 : 3'b010);
      tick();
      check("bw_csr_a", 32'(csr_a), 32'(16 + k));
      check("bw_csr_do", csr_do, 32'hA000_0000 + 32'(k));
      check("bw_we", {31'd0, csr_we}, 32'd1);
      check("bw_ack", {31'd0, wb_ack_o}, 32'd1);
    end
    bus_idle();
    tick();
    check("bw_end_ack", {31'd0, wb_ack_o}, 32'd0);
    check("bw_end_we", {31'd0, csr_we}, 32'd0);
    $display("txn burst write adr=0x00000040 beats=4");
`else
    // Without burst support cti=010 is classic: each beat needs a turnaround
    drive(1'b1, 32'h0000_0040, 32'hA000_0000, 4'hF, 3'b010);
    tick();
    check("nb_csr_a_0", 32'(csr_a), 32'd16);
    check("nb_ack_0", {31'd0, wb_ack_o}, 32'd1);
    drive(1'b1, 32'h0000_0044, 32'hA000_0001, 4'hF, 3'b111);
    tick();
    check("nb_turn_ack", {31'd0, wb_ack_o}, 32'd0);
    check("nb_turn_we", {31'd0, csr_we}, 32'd0);
    tick();
    check("nb_csr_a_1", 32'(csr_a), 32'd17);
    check("nb_ack_1", {31'd0, wb_ack_o}, 32'd1);
    check("nb_csr_do_1", csr_do, 32'hA000_0001);
    tick();
    bus_idle();
    tick();
    $display("txn cti=010 writes handled as classic");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
